// File: rtl/ryuki_datatypes.sv
// Shared trace types, output-width constant and serializer state encoding.
package ryuki_datatypes;

    localparam int unsigned TRACE_OUT_WIDTH = 32;

    // One retired-instruction record from the trace unit (72 bits).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd_addr;
        logic [2:0]  flags;
    } trace_output;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_e;

    // Number of output words needed to carry an entry of entry_w bits.
    function automatic int unsigned words_per_entry(input int unsigned entry_w,
                                                    input int unsigned word_w);
        return (entry_w + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/trace_serializer_if.sv
// Serialized word stream: valid/ready handshake with data and end-of-entry marker.
interface trace_serializer_if #(
    parameter int unsigned OUT_WIDTH = 32
);
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [OUT_WIDTH-1:0] out_data_o;
    logic                 out_last_o;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries; full/empty come from the occupancy count.
module trace_fifo
    import ryuki_datatypes::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = trace_output
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  T                           wdata_i,
    output T                           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Next pointers, count and storage contents; pointers wrap naturally at DEPTH.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; needs no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/trace_serializer.sv
// Buffers trace entries and emits each as N OUT_WIDTH-bit words, LSB slice first.
// Optional macro TRACE_DROP_COUNT_EN adds a saturating 16-bit drop counter port.
module trace_serializer
    import ryuki_datatypes::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned OUT_WIDTH = TRACE_OUT_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       trace_ready_i,
    input  trace_output                trace_i,
    trace_serializer_if.master         out_if,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
    output logic                       overflow_o
`ifdef TRACE_DROP_COUNT_EN
    ,
    output logic [15:0]                drop_count_o
`endif
);

    localparam int unsigned ENTRY_W = $bits(trace_output);
    localparam int unsigned N       = words_per_entry(ENTRY_W, OUT_WIDTH);
    localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    ser_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   overflow_q, overflow_d;
    logic [CNT_W-1:0]       fifo_count;
    trace_output            head;
    logic [N*OUT_WIDTH-1:0] padded;
    logic                   xfer, is_last, pop, full, push_en, drop;

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_output)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_en),
        .pop_i   (pop),
        .wdata_i (trace_i),
        .rdata_o (head),
        .count_o (fifo_count)
    );

    assign xfer    = (state_q == SEND) && out_if.out_ready_i;
    assign is_last = (idx_q == LAST_IDX);
    assign pop     = xfer && is_last;
    assign full    = (fifo_count == CNT_W'(DEPTH));
    // A full buffer still accepts when the head leaves on the same edge.
    assign push_en = trace_ready_i && !rst_i && (!full || pop);
    assign drop    = trace_ready_i && !rst_i && full && !pop;

    // FSM state and word index registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: start on any buffered entry, advance per transfer, pop on the last word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (is_last) begin
                        idx_d   = '0;
                        state_d = ((fifo_count > CNT_W'(1)) || push_en) ? SEND : IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs: current slice of the head entry, zero-extended; zero while idle.
    always_comb begin
        padded                = '0;
        padded[ENTRY_W-1:0]   = head;
        out_if.out_valid_o    = (state_q == SEND);
        out_if.out_last_o     = (state_q == SEND) && is_last;
        out_if.out_data_o     = '0;
        if (state_q == SEND) begin
            out_if.out_data_o = padded[idx_q*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    // Sticky overflow next value.
    always_comb begin
        overflow_d = overflow_q || drop;
    end

    // Overflow flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign fifo_count_o = fifo_count;
    assign overflow_o   = overflow_q;

`ifdef TRACE_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Drop counter next value, saturating at all-ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count_o = drop_cnt_q;
`endif

endmodule
